pic_irq_request_register: RTL and testbench



---
 rtl/pic_irq_request_register.sv | 115 +++++++++++
 tb/tb_pic_irq_request_register.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_irq_request_register.sv
// rtl/pic_irq_request_register.sv - IR pin synchroniser, trigger-mode logic and IRR for the 8259A-style PIC
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ir[7:0]      in   raw interrupt request pins (asynchronous)
//   ltim         in   trigger mode: 0 = edge, 1 = level
//   init_clr     in   ICW1 write pulse: clears IRR and re-arms edge detection
//   freeze       in   INTA sequence in progress: IRR holds, edges are parked in held_edge
//   ack_valid    in   resolver acknowledge pulse for line ack_id
//   ack_id[2:0]  in   acknowledged line index
//   imr[7:0]     in   interrupt mask, 1 = masked
//   irr[7:0]     out  registered interrupt request register
//   int_req      out  any unmasked pending request
//   ack_spurious out  one-cycle pulse: acknowledge hit a line that was idle or masked

module pic_irq_request_register #(
    parameter int SYNC_STAGES = 2,   // 2..4
    parameter int EDGE_HOLD   = 1    // 1: edge request drops when its line falls before ack
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic       init_clr,
    input  logic       freeze,
    input  logic       ack_valid,
    input  logic [2:0] ack_id,
    input  logic [7:0] imr,
    output logic [7:0] irr,
    output logic       int_req,
    output logic       ack_spurious
);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] ir_s;
    logic [7:0] ir_d;
    logic [7:0] held_edge;
    logic [7:0] rise;
    logic [7:0] ack_sel;
    logic [7:0] ack_hit;
    logic [7:0] irr_n;
    logic [7:0] held_n;
    logic [7:0] ir_d_n;
    logic       spurious_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= 8'h00;
            end
        end else begin
            sync_q[0] <= ir;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ir_s = sync_q[SYNC_STAGES-1];
    // ir_d resets to 0, so a line already high at reset release yields a rise.
    assign rise = ir_s & ~ir_d;

    // An acknowledge only clears a bit that is pending and unmasked; anything
    // else is spurious and leaves the IRR alone.
    assign ack_sel    = ack_valid ? (8'h01 << ack_id) : 8'h00;
    assign ack_hit    = ack_sel & irr & ~imr;
    assign spurious_n = ack_valid && (!irr[ack_id] || imr[ack_id]);

    always_comb begin
        irr_n  = irr;
        held_n = 8'h00;
        // Forcing ir_d high after ICW1 masks lines that are already high
        // until they go low and high again.
        ir_d_n = init_clr ? 8'hFF : ir_s;
        for (int i = 0; i < 8; i++) begin
            if (init_clr) begin
                irr_n[i]  = 1'b0;
                held_n[i] = 1'b0;
            end else begin
                // Edges seen while frozen are parked and released afterwards.
                held_n[i] = freeze ? (held_edge[i] | (rise[i] & ~ltim)) : 1'b0;
                if (ack_hit[i]) begin
                    // A fresh edge coinciding with the ack is a new request.
                    irr_n[i] = ~ltim & rise[i];
                end else if (freeze) begin
                    irr_n[i] = irr[i];
                end else if (ltim) begin
                    irr_n[i] = ir_s[i];
                end else if (EDGE_HOLD != 0) begin
                    irr_n[i] = (irr[i] | rise[i] | held_edge[i]) & ir_s[i];
                end else begin
                    irr_n[i] = irr[i] | rise[i] | held_edge[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_d         <= 8'h00;
            irr          <= 8'h00;
            held_edge    <= 8'h00;
            ack_spurious <= 1'b0;
        end else begin
            ir_d         <= ir_d_n;
            irr          <= irr_n;
            held_edge    <= held_n;
            ack_spurious <= spurious_n;
        end
    end

    assign int_req = |(irr & ~imr);

endmodule

// File: tb/tb_pic_irq_request_register.sv
// tb/tb_pic_irq_request_register.sv - directed bench for pic_irq_request_register, both EDGE_HOLD settings

module tb_pic_irq_request_register;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir = 8'h00;
    logic       ltim = 1'b0;
    logic       init_clr = 1'b0;
    logic       freeze = 1'b0;
    logic       ack_valid = 1'b0;
    logic [2:0] ack_id = 3'd0;
    logic [7:0] imr = 8'h00;

    logic [7:0] irr_h, irr_s;
    logic       int_h, int_s, spur_h, spur_s;

    always #5 clk = ~clk;

    pic_irq_request_register #(.SYNC_STAGES(SYNC), .EDGE_HOLD(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .init_clr(init_clr),
        .freeze(freeze), .ack_valid(ack_valid), .ack_id(ack_id), .imr(imr),
        .irr(irr_h), .int_req(int_h), .ack_spurious(spur_h)
    );

    pic_irq_request_register #(.SYNC_STAGES(SYNC), .EDGE_HOLD(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .init_clr(init_clr),
        .freeze(freeze), .ack_valid(ack_valid), .ack_id(ack_id), .imr(imr),
        .irr(irr_s), .int_req(int_s), .ack_spurious(spur_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: history of pin samples, one per clock edge; the synchronised view
    // is simply the sample taken SYNC-1 edges before the latest one.
    logic [7:0] seen [$];
    logic [7:0] m_irr_h, m_irr_s, m_held;
    logic       m_spur_h, m_spur_s, m_just_init;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        seen.delete();
        for (int k = 0; k < SYNC + 1; k++) seen.push_back(8'h00);
        m_irr_h = 8'h00; m_irr_s = 8'h00; m_held = 8'h00;
        m_spur_h = 1'b0; m_spur_s = 1'b0; m_just_init = 1'b0;
    endtask

    function automatic logic [7:0] next_irr(input logic [7:0] cur, input logic [7:0] s,
                                            input logic [7:0] rs, input logic [7:0] hd,
                                            input logic [7:0] hit, input bit hold,
                                            input logic frz, input logic lvl);
        logic [7:0] base;
        if (frz)      base = cur;
        else if (lvl) base = s;
        else begin
            base = cur | rs | hd;
            if (hold) base = base & s;
        end
        return (base & ~hit) | (lvl ? 8'h00 : (rs & hit));
    endfunction

    task automatic model_edge();
        int         n;
        logic [7:0] s, d, rs, sel, hit_h, hit_s;
        n     = seen.size();
        s     = seen[n-SYNC];
        d     = m_just_init ? 8'hFF : seen[n-SYNC-1];
        rs    = s & ~d;
        sel   = ack_valid ? (8'h01 << ack_id) : 8'h00;
        hit_h = sel & m_irr_h & ~imr;
        hit_s = sel & m_irr_s & ~imr;
        m_spur_h = ack_valid && (hit_h == 8'h00);
        m_spur_s = ack_valid && (hit_s == 8'h00);
        if (init_clr) begin
            m_irr_h = 8'h00; m_irr_s = 8'h00; m_held = 8'h00;
            m_just_init = 1'b1;
        end else begin
            m_irr_h = next_irr(m_irr_h, s, rs, m_held, hit_h, 1'b1, freeze, ltim);
            m_irr_s = next_irr(m_irr_s, s, rs, m_held, hit_s, 1'b0, freeze, ltim);
            m_held  = freeze ? (m_held | (ltim ? 8'h00 : rs)) : 8'h00;
            m_just_init = 1'b0;
        end
        seen.push_back(ir);
        if (seen.size() > 16) void'(seen.pop_front());
    endtask

    task automatic check_all();
        chk("irr_h", irr_h, m_irr_h);
        chk("irr_s", irr_s, m_irr_s);
        chk("int_h", {7'b0, int_h}, {7'b0, |(m_irr_h & ~imr)});
        chk("int_s", {7'b0, int_s}, {7'b0, |(m_irr_s & ~imr)});
        chk("spur_h", {7'b0, spur_h}, {7'b0, m_spur_h});
        chk("spur_s", {7'b0, spur_s}, {7'b0, m_spur_s});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1 check_all();
            @(negedge clk);
        end
    endtask

    task automatic set_imr(input logic [7:0] v);
        imr = v;
        #1;
        chk("int_h_imr", {7'b0, int_h}, {7'b0, |(m_irr_h & ~imr)});
        chk("int_s_imr", {7'b0, int_s}, {7'b0, |(m_irr_s & ~imr)});
    endtask

    initial begin
        model_reset();
        #2 check_all();
        chk("rst_irr", irr_h, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);

        // 1: edge request on bit 3, then masking
        ir = 8'h08;
        ticks(2);
        chk("t1_not_yet", irr_h, 8'h00);
        ticks(1);
        chk("t1_irr", irr_h, 8'h08);
        chk("t1_int", {7'b0, int_h}, 8'h01);
        set_imr(8'h08);
        chk("t1_masked_int", {7'b0, int_h}, 8'h00);
        chk("t1_masked_irr", irr_h, 8'h08);
        set_imr(8'h00);

        // 2: ack, then spurious re-ack
        ack_valid = 1'b1; ack_id = 3'd3;
        ticks(1);
        chk("t2_irr", irr_s, 8'h00);
        chk("t2_nospur", {7'b0, spur_h}, 8'h00);
        ticks(1);
        chk("t2_spur", {7'b0, spur_h}, 8'h01);
        ack_valid = 1'b0;
        ticks(1);
        chk("t2_spur_end", {7'b0, spur_s}, 8'h00);
        ir = 8'h00;
        ticks(3);

        // 3: edge during freeze is held and released
        freeze = 1'b1; ir = 8'h20;
        ticks(4);
        chk("t3_frozen", irr_h, 8'h00);
        freeze = 1'b0;
        ticks(1);
        chk("t3_release_h", irr_h, 8'h20);
        chk("t3_release_s", irr_s, 8'h20);
        ack_valid = 1'b1; ack_id = 3'd5;
        ticks(1);
        ack_valid = 1'b0; ir = 8'h00;
        ticks(3);

        // 4: level mode
        ltim = 1'b1; ir = 8'h81;
        ticks(3);
        chk("t4_level", irr_h, 8'h81);
        ack_valid = 1'b1; ack_id = 3'd0;
        ticks(1);
        chk("t4_ack", irr_s, 8'h80);
        ack_valid = 1'b0;
        ticks(1);
        chk("t4_reassert", irr_s, 8'h81);
        set_imr(8'h80);
        ack_valid = 1'b1; ack_id = 3'd7;
        ticks(1);
        chk("t4_masked_spur", {7'b0, spur_h}, 8'h01);
        chk("t4_masked_irr", irr_h, 8'h81);
        ack_valid = 1'b0;
        set_imr(8'h00);
        ltim = 1'b0;
        ticks(1);
        chk("t4_to_edge", irr_h, 8'h81);

        // 5: init_clr with lines high
        ir = 8'hFF;
        ticks(3);
        chk("t5_all", irr_s, 8'hFF);
        init_clr = 1'b1;
        ticks(1);
        chk("t5_clr", irr_h, 8'h00);
        init_clr = 1'b0;
        ticks(3);
        chk("t5_stays", irr_s, 8'h00);
        ir = 8'hFD;
        ticks(3);
        ir = 8'hFF;
        ticks(3);
        chk("t5_rearm_h", irr_h, 8'h02);
        chk("t5_rearm_s", irr_s, 8'h02);
        init_clr = 1'b1;
        ticks(1);
        init_clr = 1'b0; ir = 8'h00;
        ticks(3);

        // 6: EDGE_HOLD comparison
        ir = 8'h04;
        ticks(4);
        chk("t6_set", irr_h, 8'h04);
        ir = 8'h00;
        ticks(2);
        chk("t6_h_late", irr_h, 8'h04);
        ticks(1);
        chk("t6_h_drop", irr_h, 8'h00);
        chk("t6_s_sticky", irr_s, 8'h04);
        ack_valid = 1'b1; ack_id = 3'd2;
        ticks(1);
        chk("t6_h_spur", {7'b0, spur_h}, 8'h01);
        chk("t6_s_ack", irr_s, 8'h00);
        ack_valid = 1'b0;

        // reset mid-freeze with a held edge pending, line high at release
        freeze = 1'b1; ir = 8'h08;
        ticks(3);
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1; freeze = 1'b0;
        ticks(3);
        chk("rel_rise", irr_h, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
